// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Purpose  : Prefetches one framebuffer row per display line into a ping-pong
//            line buffer and streams horizontally upscaled rrr_ggg_bb pixels.
// Revision : 1.0  initial release
// ============================================================================
module vga_frame_reader #(
  parameter int          FB_WIDTH   = 160,
  parameter int          FB_HEIGHT  = 120,
  parameter int          SCALE      = 4,
  parameter logic [14:0] BASE_ADDR  = 15'h0000,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic        pix_en,
  output logic [14:0] vga_addr,
  input  logic [15:0] vga_data,
  output logic [7:0]  color,
  output logic        fetch_busy,
  output logic        underrun
);

  localparam int         WORDS = FB_WIDTH / 2;
  localparam int         KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int         SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int         PW    = $clog2(FB_WIDTH + 1);
  localparam int         DW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [8:0] LINES = 9'(FB_HEIGHT * SCALE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [DW-1:0]                drain_q, drain_d;
  logic [14:0]                  addr_q, addr_d;
  logic                         fill_q, fill_d;
  logic [1:0]                   valid_q, valid_d;
  logic                         underrun_q, underrun_d;
  logic [RD_LATENCY-1:0][KW:0]  tag_q, tag_d;
  logic [SW-1:0]                sub_q, sub_d;
  logic [PW-1:0]                pix_q, pix_d;
  logic [7:0]                   color_q, color_d;
  logic [15:0]                  line_buf_q [2][WORDS];

  logic                         wr_en_d;
  logic                         wr_bank_d;
  logic [KW-1:0]                wr_idx_d;
  logic [15:0]                  wr_data_d;

  logic                         ls_go;
  logic [14:0]                  row;
  logic [14:0]                  fetch_base;
  logic                         cur_disp;
  logic [SW-1:0]                cur_sub;
  logic [PW-1:0]                cur_pix;
  logic                         in_row;
  logic [KW-1:0]                rd_idx;
  logic [15:0]                  rd_word;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    drain_d    = drain_q;
    addr_d     = addr_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;
    ls_go      = enable && line_start;
    row        = 15'(32'(line_y) / SCALE);
    fetch_base = BASE_ADDR + row * 15'(WORDS);

    // Tag delay line {valid, k}: the word driven now lands RD_LATENCY cycles later
    tag_d[0] = {(state_q == S_ISSUE), k_q};
    for (int i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
    if (!enable || line_start) tag_d = '0;

    wr_en_d   = tag_q[RD_LATENCY-1][KW] && enable && !ls_go;
    wr_bank_d = fill_q;
    wr_idx_d  = tag_q[RD_LATENCY-1][KW-1:0];
    wr_data_d = vga_data;

    if (!enable) begin
      state_d = S_IDLE;
    end else if (ls_go) begin
      fill_d          = ~fill_q;
      valid_d[fill_d] = 1'b0;
      k_d             = '0;
      drain_d         = '0;
      if (state_q != S_IDLE) underrun_d = 1'b1;
      if (line_y < LINES) begin
        state_d = S_ISSUE;
        addr_d  = fetch_base;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (k_q == KW'(WORDS - 1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            k_d    = k_q + KW'(1);
            addr_d = addr_q + 15'd1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(RD_LATENCY - 1)) begin
            state_d         = S_IDLE;
            valid_d[fill_q] = 1'b1;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        default: ;
      endcase
    end

    // A line_start coinciding with pix_en shows pixel 0 of the incoming bank
    cur_disp = ls_go ? fill_q : ~fill_q;
    cur_sub  = ls_go ? '0 : sub_q;
    cur_pix  = ls_go ? '0 : pix_q;
    in_row   = cur_pix < PW'(FB_WIDTH);
    rd_idx   = in_row ? KW'(cur_pix >> 1) : '0;
    rd_word  = line_buf_q[cur_disp][rd_idx];

    color_d = 8'h00;
    if (enable && pix_en && valid_q[cur_disp] && in_row)
      color_d = cur_pix[0] ? rd_word[7:0] : rd_word[15:8];

    sub_d = cur_sub;
    pix_d = cur_pix;
    if (pix_en && in_row) begin
      if (cur_sub == SW'(SCALE - 1)) begin
        sub_d = '0;
        pix_d = cur_pix + PW'(1);
      end else begin
        sub_d = cur_sub + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      drain_q    <= '0;
      addr_q     <= BASE_ADDR;
      fill_q     <= 1'b0;
      valid_q    <= '0;
      underrun_q <= 1'b0;
      tag_q      <= '0;
      sub_q      <= '0;
      pix_q      <= '0;
      color_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      addr_q     <= addr_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      tag_q      <= tag_d;
      sub_q      <= sub_d;
      pix_q      <= pix_d;
      color_q    <= color_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en_d) line_buf_q[wr_bank_d][wr_idx_d] <= wr_data_d;
  end

  assign vga_addr   = addr_q;
  assign color      = color_q;
  assign fetch_busy = (state_q != S_IDLE);
  assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// Bench for vga_frame_reader: latency-1 and latency-3 instances share stimulus
// and are checked against a framebuffer model through address/colour queues.
module tb_vga_frame_reader;
  localparam int FB_WIDTH = 160;
  localparam int SCALE    = 4;
  localparam int WORDS    = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        line_start = 1'b0;
  logic        pix_en = 1'b0;
  logic [8:0]  line_y = '0;
  logic [14:0] addr1, addr3;
  logic [15:0] data1, data3;
  logic [7:0]  color1, color3;
  logic        busy1, busy3, und1, und3;
  logic [14:0] pipe1 = '0;
  logic [14:0] pipe3 [3];

  int errors = 0;
  int checks = 0;
  logic [14:0] last_addr = 15'h0000;
  logic [14:0] addr_q [$];
  logic [7:0]  col_q [$];

  typedef struct {
    logic [8:0]  y;
    bit          fetch;
    logic [14:0] fa;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  // High and low bytes differ so left/right pixel selection is observable
  function automatic logic [15:0] word_of(input logic [14:0] a);
    return {a[7:0], a[7:0] ^ 8'hA5};
  endfunction

  function automatic logic [7:0] pix_color(input logic [14:0] base, input int px);
    logic [15:0] w;
    w = word_of(base + 15'(px / 2));
    return px[0] ? w[7:0] : w[15:8];
  endfunction

  always @(posedge clk) begin
    pipe1    <= addr1;
    pipe3[0] <= addr3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign data1 = word_of(pipe1);
  assign data3 = word_of(pipe3[2]);

  vga_frame_reader #(.RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
    .line_y(line_y), .pix_en(pix_en), .vga_addr(addr1), .vga_data(data1),
    .color(color1), .fetch_busy(busy1), .underrun(und1)
  );

  vga_frame_reader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
    .line_y(line_y), .pix_en(pix_en), .vga_addr(addr3), .vga_data(data3),
    .color(color3), .fetch_busy(busy3), .underrun(und3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_color();
    logic [7:0] exp_c;
    exp_c = col_q.pop_front();
    check("color L1", color1, exp_c);
    check("color L3", color3, exp_c);
  endtask

  task automatic check_reset_state();
    check("reset addr L1", addr1, 15'h0000);
    check("reset addr L3", addr3, 15'h0000);
    check("reset busy L1", busy1, 1'b0);
    check("reset busy L3", busy3, 1'b0);
    check("reset color L1", color1, 8'h00);
    check("reset color L3", color3, 8'h00);
    check("reset underrun L1", und1, 1'b0);
    check("reset underrun L3", und3, 1'b0);
  endtask

  // One display line: line_start, full fetch check, then a 641-pixel stream
  task automatic do_line(input logic [8:0] y, input bit exp_fetch, input logic [14:0] fa,
                         input bit disp_ok, input logic [14:0] disp_base,
                         input bit exp_und, input bit ls_pix);
    logic [14:0] ea;
    line_start = 1'b1;
    line_y     = y;
    pix_en     = ls_pix;
    if (exp_fetch)
      for (int k = 0; k < WORDS; k++) addr_q.push_back(fa + 15'(k));
    if (ls_pix) col_q.push_back(disp_ok ? pix_color(disp_base, 0) : 8'h00);
    tick();
    line_start = 1'b0;
    pix_en     = 1'b0;
    if (ls_pix) check_color();
    check("underrun L1", und1, exp_und);
    check("underrun L3", und3, exp_und);
    for (int c = 0; c < WORDS + 3; c++) begin
      check("busy L1", busy1, exp_fetch && (c < WORDS + 1));
      check("busy L3", busy3, exp_fetch && (c < WORDS + 3));
      if (exp_fetch && c < WORDS) begin
        ea = addr_q.pop_front();
        check("fetch addr L1", addr1, ea);
        check("fetch addr L3", addr3, ea);
      end else if (!exp_fetch) begin
        check("addr hold L1", addr1, last_addr);
        check("addr hold L3", addr3, last_addr);
      end
      tick();
    end
    check("busy end L1", busy1, 1'b0);
    check("busy end L3", busy3, 1'b0);
    if (exp_fetch) last_addr = fa + 15'(WORDS - 1);
    for (int p = (ls_pix ? 1 : 0); p <= FB_WIDTH * SCALE; p++) begin
      pix_en = 1'b1;
      col_q.push_back((disp_ok && p < FB_WIDTH * SCALE) ? pix_color(disp_base, p / SCALE) : 8'h00);
      tick();
      check_color();
    end
    pix_en = 1'b0;
    col_q.push_back(8'h00);
    tick();
    check_color();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{9'd0,   1'b1, 15'd0};
    vecs[1] = '{9'd7,   1'b1, 15'd80};
    vecs[2] = '{9'd479, 1'b1, 15'd9520};
    vecs[3] = '{9'd480, 1'b0, 15'd0};
    vecs[4] = '{9'd200, 1'b1, 15'd4000};
    vecs[5] = '{9'd3,   1'b1, 15'd0};
    vecs[6] = '{9'd480, 1'b0, 15'd0};

    reset = 1'b1;
    repeat (3) tick();
    check_reset_state();
    reset = 1'b0;

    // No line_start yet: everything stays black and idle
    pix_en = 1'b1;
    for (int i = 0; i < FB_WIDTH * SCALE; i++) begin
      tick();
      check("idle color L1", color1, 8'h00);
      check("idle color L3", color3, 8'h00);
      check("idle busy L1", busy1, 1'b0);
      check("idle addr L1", addr1, 15'h0000);
    end
    pix_en = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      do_line(vecs[i].y, vecs[i].fetch, vecs[i].fa,
              (i > 0) ? vecs[(i > 0) ? i - 1 : 0].fetch : 1'b0,
              vecs[(i > 0) ? i - 1 : 0].fa, 1'b0, 1'b0);

    // Second line_start 40 cycles into a fetch
    line_start = 1'b1;
    line_y     = 9'd0;
    tick();
    line_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      check("partial addr L1", addr1, 15'(c));
      check("partial addr L3", addr3, 15'(c));
      tick();
    end
    do_line(9'd8, 1'b1, 15'd160, 1'b0, 15'd0, 1'b1, 1'b0);
    do_line(9'd4, 1'b1, 15'd80, 1'b1, 15'd160, 1'b1, 1'b1);
    do_line(9'd480, 1'b0, 15'd0, 1'b1, 15'd80, 1'b1, 1'b0);

    // Disabled: line_start ignored, underrun retained
    enable     = 1'b0;
    line_start = 1'b1;
    line_y     = 9'd0;
    tick();
    line_start = 1'b0;
    tick();
    check("disabled busy L1", busy1, 1'b0);
    check("disabled busy L3", busy3, 1'b0);
    check("disabled addr L1", addr1, last_addr);
    check("disabled underrun L3", und3, 1'b1);
    enable = 1'b1;
    tick();

    // Reset in the middle of ISSUE
    line_start = 1'b1;
    line_y     = 9'd4;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
    check("mid-issue busy L3", busy3, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_state();
    reset     = 1'b0;
    last_addr = 15'h0000;
    do_line(9'd8, 1'b1, 15'd160, 1'b0, 15'd0, 1'b0, 1'b0);
    do_line(9'd480, 1'b0, 15'd0, 1'b1, 15'd160, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Read-side initiator on the memory controller's display port (vga_addr/vga_data); the CPU side writes the framebuffer, this block reads it back out.
- Prefetches one framebuffer row per display line into a ping-pong line buffer.
- Streams 8-bit rrr_ggg_bb pixels to the VGA pipeline with integer horizontal upscaling.
- Sits between the memory controller and the VGA timing/display logic.

Parameters:
FB_WIDTH, 160, framebuffer pixels per row; must be even (2 pixels per 16-bit word).
FB_HEIGHT, 120, framebuffer rows.
SCALE, 4, integer upscale factor in both axes; display is FB_WIDTH*SCALE x FB_HEIGHT*SCALE.
BASE_ADDR, 15'h0000, word address of framebuffer pixel (0,0).
RD_LATENCY, 1, cycles from vga_addr driven to vga_data valid; 1..3.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  block enable; low = idle and black output
line_start  in  1  one-cycle pulse at the start of horizontal blanking before each display line
line_y  in  9  display row (0..FB_HEIGHT*SCALE-1) of the line shown after the NEXT line_start; sampled with line_start
pix_en  in  1  one pulse per visible pixel clock
vga_addr  out  15  word read address to memory controller
vga_data  in  16  read data; [15:8] = left pixel, [7:0] = right pixel
color  out  8  pixel rrr_ggg_bb, registered
fetch_busy  out  1  high while a row fetch is in progress
underrun  out  1  sticky: a fetch was still busy when line_start arrived

Behaviour:
- Reset (synchronous, active-high), all outputs: vga_addr=BASE_ADDR, color=0, fetch_busy=0, underrun=0. FSM goes to IDLE; both buffer valid flags are cleared.
- Reset mid-fetch aborts the fetch; no buffer write occurs in the reset cycle.
- Buffers: two banks of FB_WIDTH/2 words, DISP and FILL, each with a valid flag.
- On line_start (enable=1):
  - Swap the bank roles.
  - Clear the display counters.
  - Clear the new FILL bank's valid flag.
  - Latch row = line_y / SCALE.
  - If line_y < FB_HEIGHT*SCALE, start a fetch; otherwise no fetch (FILL stays invalid, so that line is black).
- Row address: BASE_ADDR + row*(FB_WIDTH/2) + k, for k = 0..FB_WIDTH/2-1. Arithmetic is 15-bit and wraps modulo 2^15.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE:
  - ISSUE: drive one address per cycle for FB_WIDTH/2 cycles.
  - Data for address k is captured into FILL[k] exactly RD_LATENCY cycles after k was driven; capture uses a delay-line tag of {valid, k}.
  - DRAIN: RD_LATENCY cycles, then set the FILL valid flag and return to IDLE.
  - Total fetch = FB_WIDTH/2 + RD_LATENCY cycles. fetch_busy is high in ISSUE and DRAIN.
  - vga_addr holds its last value in IDLE.
- line_start while fetch_busy=1:
  - Set underrun=1; it stays set until reset.
  - Abort the fetch and discard in-flight captures.
  - The aborted bank stays invalid after the swap, so that line is black.
  - The new fetch starts the same cycle.
- Display:
  - Each pix_en cycle advances a sub-counter 0..SCALE-1. On wrap, the pixel index increments.
  - Word = pixel>>1; byte = pixel[0] ? [7:0] : [15:8].
  - color is updated the cycle after pix_en (latency 1).
  - color=0 when any of: pix_en was low the prior cycle, DISP invalid, pixel index >= FB_WIDTH, or enable=0.
  - Extra pix_en beyond FB_WIDTH*SCALE outputs 0; counters saturate.
- pix_en and line_start in the same cycle: line_start takes priority; counters clear and that pix_en displays pixel 0 of the new DISP bank.
- enable=0: abort any fetch, FSM to IDLE, ignore line_start, color=0. underrun and bank contents are retained.

Test Plan:
- Reset, then pix_en held 640 cycles with no line_start -> color=0 throughout; vga_addr=0x0000; fetch_busy=0.
- Framebuffer model word(a)=a[7:0]*257, line_start with line_y=0 -> vga_addr 0..79 on consecutive cycles; fetch_busy high exactly 81 cycles (RD_LATENCY=1); underrun=0.
- Second line_start, then 640 pix_en -> color sequence 0x00 x4, 0x00 x4, 0x01 x4, 0x01 x4, ... 0x4F x4. Each color appears the cycle after its pix_en; the 641st pix_en gives 0.
- line_start with line_y=7 -> fetch addresses start at 1*80=80. line_y=479 -> starts at 119*80=9520. line_y=480 -> no fetch and the following line is black.
- Second line_start 40 cycles after the first -> underrun=1 and stays 1. The partially fetched line displays black; the new fetch completes normally.
- RD_LATENCY=3 build with line_start mid-fetch and reset asserted mid-ISSUE -> no stale capture; outputs return to reset values the next cycle.
